bram_dp_be_param: RTL and testbench

- Parametrised single-clock true dual-port RAM for SCPU instruction and data memory.
- Supersedes the fixed 8-bit x 4096 memory shell with configurable word width, depth, per-byte write enables, 1- or 2-cycle read latency and selectable read-during-write mode.
- A built-in fill engine writes FILL_WORD, the RISC-V NOP by default, to every location after reset.
- Port A serves the fetch stage or loader. Port B serves the LSU.

---
 rtl/bram_dp_be_param.sv | 163 ++++++++++++++++
 tb/tb_bram_dp_be_param.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_dp_be_param.sv
// Single-clock true dual-port RAM with per-byte write enables, 1/2-cycle read latency,
// selectable same-port read-during-write mode and a post-reset fill engine.
module bram_dp_be_param #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned WRITE_MODE   = 0,
    parameter int unsigned INIT_FILL    = 1,
    parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(32'h00000013)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_busy,
    input  logic                  a_en,
    input  logic [DATA_W/8-1:0]   a_we,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_din,
    output logic [DATA_W-1:0]     a_dout,
    output logic                  a_valid,
    input  logic                  b_en,
    input  logic [DATA_W/8-1:0]   b_we,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [DATA_W-1:0]     b_din,
    output logic [DATA_W-1:0]     b_dout,
    output logic                  b_valid
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                fill_we_c;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Fill engine state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= (INIT_FILL != 0) ? S_FILL : S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Fill engine next state: one word per cycle, leave after the last address
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fill_we_c = 1'b0;
        case (state_q)
            S_FILL: begin
                fill_we_c = 1'b1;
                if (32'(cnt_q) == DEPTH - 1) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign init_busy = (state_q == S_FILL);

    logic              a_acc_c, b_acc_c;
    logic              a_hit_c, b_hit_c;
    logic [IDX_W-1:0]  a_idx_c, b_idx_c;
    logic [DATA_W-1:0] a_old_c, b_old_c;
    logic [DATA_W-1:0] a_mrg_c, b_mrg_c;
    logic [DATA_W-1:0] a_rd_c, b_rd_c;

    assign a_acc_c = a_en && (state_q == S_RUN);
    assign b_acc_c = b_en && (state_q == S_RUN);
    assign a_hit_c = 32'(a_addr) < DEPTH;
    assign b_hit_c = 32'(b_addr) < DEPTH;
    assign a_idx_c = a_addr[IDX_W-1:0];
    assign b_idx_c = b_addr[IDX_W-1:0];
    assign a_old_c = a_hit_c ? mem[a_idx_c] : '0;
    assign b_old_c = b_hit_c ? mem[b_idx_c] : '0;

    // Same-port merge of write data over the stored word (write-first view)
    always_comb begin
        a_mrg_c = a_old_c;
        b_mrg_c = b_old_c;
        for (int i = 0; i < NB; i++) begin
            if (a_we[i]) a_mrg_c[8*i +: 8] = a_din[8*i +: 8];
            if (b_we[i]) b_mrg_c[8*i +: 8] = b_din[8*i +: 8];
        end
    end

    assign a_rd_c = ((WRITE_MODE != 0) && a_hit_c) ? a_mrg_c : a_old_c;
    assign b_rd_c = ((WRITE_MODE != 0) && b_hit_c) ? b_mrg_c : b_old_c;

    // Array writes; port A is applied last so it wins per byte on collisions
    always_ff @(posedge clk) begin
        if (fill_we_c) begin
            mem[cnt_q[IDX_W-1:0]] <= FILL_WORD;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (b_acc_c && b_hit_c && b_we[i]) mem[b_idx_c][8*i +: 8] <= b_din[8*i +: 8];
                if (a_acc_c && a_hit_c && a_we[i]) mem[a_idx_c][8*i +: 8] <= a_din[8*i +: 8];
            end
        end
    end

    logic              a_s1_v, b_s1_v;
    logic [DATA_W-1:0] a_s1_d, b_s1_d;

    // First read stage: capture data only on an accepted access so dout holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s1_v <= 1'b0;
            a_s1_d <= '0;
            b_s1_v <= 1'b0;
            b_s1_d <= '0;
        end else begin
            a_s1_v <= a_acc_c;
            b_s1_v <= b_acc_c;
            if (a_acc_c) a_s1_d <= a_rd_c;
            if (b_acc_c) b_s1_d <= b_rd_c;
        end
    end

    if (READ_LATENCY == 2) begin : g_rl2
        logic              a_s2_v, b_s2_v;
        logic [DATA_W-1:0] a_s2_d, b_s2_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_s2_v <= 1'b0;
                a_s2_d <= '0;
                b_s2_v <= 1'b0;
                b_s2_d <= '0;
            end else begin
                a_s2_v <= a_s1_v;
                b_s2_v <= b_s1_v;
                if (a_s1_v) a_s2_d <= a_s1_d;
                if (b_s1_v) b_s2_d <= b_s1_d;
            end
        end

        assign a_dout  = a_s2_d;
        assign a_valid = a_s2_v;
        assign b_dout  = b_s2_d;
        assign b_valid = b_s2_v;
    end else begin : g_rl1
        assign a_dout  = a_s1_d;
        assign a_valid = a_s1_v;
        assign b_dout  = b_s1_d;
        assign b_valid = b_s1_v;
    end

endmodule

// File: tb/tb_bram_dp_be_param.sv
// Bench for bram_dp_be_param: default instance plus a 2-cycle / 1000-word / write-first
// instance, both checked every cycle against a word-array reference model.
module tb_bram_dp_be_param;

    logic        clk;
    logic        rst_n;
    logic        a_en, b_en;
    logic [3:0]  a_we, b_we;
    logic [9:0]  a_addr, b_addr;
    logic [31:0] a_din, b_din;

    logic        busy0, busy1;
    logic [31:0] ad0, bd0, ad1, bd1;
    logic        av0, bv0, av1, bv1;

    bram_dp_be_param #(
        .DATA_W(32), .DEPTH(1024), .ADDR_W(10),
        .READ_LATENCY(1), .WRITE_MODE(0), .INIT_FILL(1)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .init_busy(busy0),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(ad0), .a_valid(av0),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(bd0), .b_valid(bv0)
    );

    bram_dp_be_param #(
        .DATA_W(32), .DEPTH(1000), .ADDR_W(10),
        .READ_LATENCY(2), .WRITE_MODE(1), .INIT_FILL(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .init_busy(busy1),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(ad1), .a_valid(av1),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(bd1), .b_valid(bv1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain word array per instance, reads before writes each cycle
    logic [31:0] rm [2][1024];
    int          fill_left [2];
    logic        st_v [2][2];
    logic [31:0] st_d [2][2];
    logic        ex_v [2][2];
    logic [31:0] ex_d [2][2];
    int          n_vec, n_err;

    function automatic int dep(input int k);
        return (k == 0) ? 1024 : 1000;
    endfunction
    function automatic int lat(input int k);
        return (k == 0) ? 1 : 2;
    endfunction
    function automatic int wmode(input int k);
        return (k == 0) ? 0 : 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %08h expected %08h", nm, $time, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0b expected %0b", nm, $time, act, exp);
        end
    endtask

    task automatic model_edge(input int k);
        logic        pen [2];
        logic [3:0]  pwe [2];
        logic [9:0]  pad [2];
        logic [31:0] pdi [2];
        logic        nv  [2];
        logic [31:0] nd  [2];
        pen[0] = a_en; pwe[0] = a_we; pad[0] = a_addr; pdi[0] = a_din;
        pen[1] = b_en; pwe[1] = b_we; pad[1] = b_addr; pdi[1] = b_din;
        for (int p = 0; p < 2; p++) begin
            nv[p] = 1'b0;
            nd[p] = 32'h0;
        end
        if (fill_left[k] > 0) begin
            rm[k][dep(k) - fill_left[k]] = 32'h00000013;
            fill_left[k]--;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (pen[p]) begin
                    nv[p] = 1'b1;
                    if (int'(pad[p]) < dep(k)) begin
                        nd[p] = rm[k][pad[p]];
                        if (wmode(k) == 1)
                            for (int b = 0; b < 4; b++)
                                if (pwe[p][b]) nd[p][8*b +: 8] = pdi[p][8*b +: 8];
                    end
                end
            end
            for (int p = 1; p >= 0; p--)
                if (pen[p] && int'(pad[p]) < dep(k))
                    for (int b = 0; b < 4; b++)
                        if (pwe[p][b]) rm[k][pad[p]][8*b +: 8] = pdi[p][8*b +: 8];
        end
        for (int p = 0; p < 2; p++) begin
            if (lat(k) == 1) begin
                ex_v[k][p] = nv[p];
                if (nv[p]) ex_d[k][p] = nd[p];
            end else begin
                ex_v[k][p] = st_v[k][p];
                if (st_v[k][p]) ex_d[k][p] = st_d[k][p];
                st_v[k][p] = nv[p];
                st_d[k][p] = nd[p];
            end
        end
    endtask

    task automatic check_all();
        chk1("init_busy0", busy0, fill_left[0] > 0);
        chk1("a_valid0", av0, ex_v[0][0]);
        chk("a_dout0", ad0, ex_d[0][0]);
        chk1("b_valid0", bv0, ex_v[0][1]);
        chk("b_dout0", bd0, ex_d[0][1]);
        chk1("init_busy1", busy1, fill_left[1] > 0);
        chk1("a_valid1", av1, ex_v[1][0]);
        chk("a_dout1", ad1, ex_d[1][0]);
        chk1("b_valid1", bv1, ex_v[1][1]);
        chk("b_dout1", bd1, ex_d[1][1]);
    endtask

    task automatic step();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        a_en = 1'b0; a_we = 4'h0; a_addr = 10'd0; a_din = 32'h0;
        b_en = 1'b0; b_we = 4'h0; b_addr = 10'd0; b_din = 32'h0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            fill_left[k] = dep(k);
            for (int p = 0; p < 2; p++) begin
                st_v[k][p] = 1'b0; st_d[k][p] = 32'h0;
                ex_v[k][p] = 1'b0; ex_d[k][p] = 32'h0;
            end
        end
        check_all();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_fill();
        while (fill_left[0] > 0 || fill_left[1] > 0) step();
    endtask

    typedef struct {
        logic        a_en;
        logic [3:0]  a_we;
        logic [9:0]  a_addr;
        logic [31:0] a_din;
        logic        b_en;
        logic [3:0]  b_we;
        logic [9:0]  b_addr;
        logic [31:0] b_din;
        logic        chk_a;
        logic [31:0] exp_a;
        logic        chk_b;
        logic [31:0] exp_b;
    } vec_t;

    vec_t tbl [10];

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 1024; i++) rm[k][i] = 32'h0;

        // Expectations below are for the default (1-cycle, read-first) instance
        tbl[0] = '{1'b1, 4'hF, 10'd5,    32'hDEADBEEF, 1'b0, 4'h0, 10'd0,   32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
        tbl[1] = '{1'b1, 4'h1, 10'd5,    32'h000000AA, 1'b0, 4'h0, 10'd0,   32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
        tbl[2] = '{1'b1, 4'h0, 10'd5,    32'h0,        1'b0, 4'h0, 10'd0,   32'h0,        1'b1, 32'hDEADBEAA, 1'b0, 32'h0};
        tbl[3] = '{1'b1, 4'hF, 10'd7,    32'h11111111, 1'b0, 4'h0, 10'd0,   32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
        tbl[4] = '{1'b1, 4'hF, 10'd7,    32'h22222222, 1'b1, 4'h0, 10'd7,   32'h0,        1'b1, 32'h11111111, 1'b1, 32'h11111111};
        tbl[5] = '{1'b1, 4'h3, 10'd9,    32'hAAAAAAAA, 1'b1, 4'h6, 10'd9,   32'hBBBBBBBB, 1'b1, 32'h00000013, 1'b1, 32'h00000013};
        tbl[6] = '{1'b1, 4'h0, 10'd9,    32'h0,        1'b1, 4'h0, 10'd7,   32'h0,        1'b1, 32'h00BBAAAA, 1'b1, 32'h22222222};
        tbl[7] = '{1'b1, 4'h0, 10'd0,    32'h0,        1'b1, 4'h0, 10'd511, 32'h0,        1'b1, 32'h00000013, 1'b1, 32'h00000013};
        tbl[8] = '{1'b1, 4'h0, 10'd1023, 32'h0,        1'b1, 4'h0, 10'd1023,32'h0,        1'b1, 32'h00000013, 1'b1, 32'h00000013};
        tbl[9] = '{1'b0, 4'h0, 10'd0,    32'h0,        1'b0, 4'h0, 10'd0,   32'h0,        1'b0, 32'h0,        1'b0, 32'h0};

        idle();
        rst_n = 1'b1;
        #2;
        do_reset();
        wait_fill();

        for (int i = 0; i < 10; i++) begin
            a_en = tbl[i].a_en; a_we = tbl[i].a_we; a_addr = tbl[i].a_addr; a_din = tbl[i].a_din;
            b_en = tbl[i].b_en; b_we = tbl[i].b_we; b_addr = tbl[i].b_addr; b_din = tbl[i].b_din;
            step();
            if (tbl[i].chk_a) begin
                chk("tbl_a_dout", ad0, tbl[i].exp_a);
                chk1("tbl_a_valid", av0, 1'b1);
            end
            if (tbl[i].chk_b) begin
                chk("tbl_b_dout", bd0, tbl[i].exp_b);
                chk1("tbl_b_valid", bv0, 1'b1);
            end
        end

        // Two-cycle latency and out-of-range handling on the 1000-word instance
        idle(); a_en = 1'b1; a_we = 4'hF; a_addr = 10'd3;    a_din = 32'h33333333; step();
        idle(); a_en = 1'b1; a_we = 4'hF; a_addr = 10'd1010; a_din = 32'hFFFFFFFF; step();
        idle(); a_en = 1'b1; a_addr = 10'd3;    step();
        idle(); a_en = 1'b1; a_addr = 10'd4;    step();
        chk("lat2_rd3", ad1, 32'h33333333);
        chk1("lat2_v3", av1, 1'b1);
        idle(); a_en = 1'b1; a_addr = 10'd1010; step();
        idle(); step();
        chk("oor_rd", ad1, 32'h0);
        chk1("oor_v", av1, 1'b1);
        step();
        chk1("oor_v_drop", av1, 1'b0);
        chk("oor_hold", ad1, 32'h0);

        // Random traffic, biased toward a few hot addresses to provoke collisions
        for (int i = 0; i < 1500; i++) begin
            a_en   = 1'($urandom_range(0, 1));
            a_we   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            a_addr = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 15));
            a_din  = $urandom;
            b_en   = 1'($urandom_range(0, 1));
            b_we   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            b_addr = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 15));
            b_din  = $urandom;
            step();
        end
        idle();
        step();
        step();

        // Reset in the middle of fill, then a full refill
        do_reset();
        repeat (300) step();
        a_en = 1'b1; a_addr = 10'd2;
        do_reset();
        chk("midfill_a_dout0", ad0, 32'h0);
        chk1("midfill_busy0", busy0, 1'b1);
        wait_fill();
        idle(); a_en = 1'b1; a_addr = 10'd1023; step();
        chk("refill_1023", ad0, 32'h00000013);
        idle(); step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
